// File: rtl/dbscan_result_streamer.sv
// dbscan_result_streamer: walks point memory 0..count-1 after clustering and
// emits one {idx, coords, label, core, last} record per point on a valid/ready stream.
module dbscan_result_streamer #(
  parameter int MAX_N = 64,
  localparam int AW = $clog2(MAX_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   n_points,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [7:0]    mem_x,
  input  logic [7:0]    mem_y,
  input  logic [7:0]    mem_z,
  input  logic [3:0]    mem_label,
  input  logic          mem_core,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [7:0]    out_x,
  output logic [7:0]    out_y,
  output logic [7:0]    out_z,
  output logic [3:0]    out_label,
  output logic          out_core,
  output logic          out_last
);
  localparam int RW = AW + 30;
  localparam logic [AW:0] MAX_C = (AW+1)'(MAX_N);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   count_q, count_d;
  logic [RW-1:0] rec_q, rec_d;
  logic          valid_q, valid_d, done_q, done_d, is_last;
  assign is_last = {1'b0, idx_q} == count_q - 1'b1;
  assign raddr = state_q == STREAM ? idx_q : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign out_valid = valid_q;
  assign {out_last, out_core, out_label, out_z, out_y, out_x, out_idx} = rec_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    count_d = count_q;
    rec_d = rec_q;
    valid_d = valid_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        done_d = n_points == '0;
        if (n_points != '0) begin
          count_d = n_points > MAX_C ? MAX_C : n_points;
          idx_d = '0;
          state_d = STREAM;
        end
      end
      // The output register is the only buffer: refill it only when empty or draining.
      STREAM: if (!valid_q || out_ready) begin
        rec_d = {is_last, mem_core, mem_label, mem_z, mem_y, mem_x, idx_q};
        valid_d = 1'b1;
        idx_d = idx_q + 1'b1;
        state_d = is_last ? FLUSH : STREAM;
      end
      FLUSH: if (valid_q && out_ready) begin
        valid_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      count_q <= '0;
      rec_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      count_q <= count_d;
      rec_q <= rec_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_dbscan_result_streamer.sv
// tb_dbscan_result_streamer: directed dumps against a scoreboard that derives each
// expected record from the memory preload rule x=i, y=2i, z=3i, label=i%16, core=i[0].
module tb_dbscan_result_streamer;
  logic       clk = 0, rst_n, start, busy, done, out_valid, out_ready, mem_core, out_core, out_last;
  logic [6:0] n_points;
  logic [5:0] raddr, out_idx;
  logic [7:0] mem_x, mem_y, mem_z, out_x, out_y, out_z;
  logic [3:0] mem_label, out_label;
  int checks = 0, errors = 0;
  int mode, exp_cnt, dump_id, seen_id, tcur, hs_cnt, last_hs_t;
  bit stall;
  logic [63:0] prev_rec;

  dbscan_result_streamer #(.MAX_N(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_points(n_points), .busy(busy), .done(done),
    .raddr(raddr), .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z), .mem_label(mem_label),
    .mem_core(mem_core), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_label(out_label), .out_core(out_core),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  assign mem_x = {2'b00, raddr};
  assign mem_y = {1'b0, raddr, 1'b0};
  assign mem_z = mem_x + mem_y;
  assign mem_label = raddr[3:0];
  assign mem_core = raddr[0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must deliver the next point in order, with its preload-derived fields.
  always @(negedge clk) begin
    if (!rst_n) stall = 0;
    else begin
      int loaded;
      if (dump_id != seen_id) begin
        hs_cnt = 0;
        seen_id = dump_id;
        stall = 0;
      end
      loaded = hs_cnt + int'(out_valid);
      if (!busy) chk("raddr_idle", raddr, 0);
      else if (loaded < exp_cnt) chk("raddr", raddr, loaded);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_rec", {out_idx, out_x, out_y, out_z, out_label, out_core, out_last}, prev_rec);
      end
      if (out_valid && out_ready) begin
        chk("rec_count", hs_cnt < exp_cnt, 1);
        chk("rec_idx", out_idx, hs_cnt);
        chk("rec_x", out_x, hs_cnt);
        chk("rec_y", out_y, 2 * hs_cnt);
        chk("rec_z", out_z, 3 * hs_cnt);
        chk("rec_label", out_label, hs_cnt % 16);
        chk("rec_core", out_core, hs_cnt % 2);
        chk("rec_last", out_last, hs_cnt == exp_cnt - 1);
        if (mode == 0) chk("rec_time", tcur, hs_cnt + 2);
        hs_cnt++;
        last_hs_t = tcur;
      end
      stall = out_valid && !out_ready;
      prev_rec = {28'd0, out_idx, out_x, out_y, out_z, out_label, out_core, out_last};
    end
  end

  // md 0: ready always high; md 1: ready pattern 1,0,0 repeating.
  task automatic dump(input int n, input int md, input int restart_t, input int kill_t);
    int cnt;
    bit seen_done;
    cnt = n > 64 ? 64 : n;
    seen_done = 0;
    mode = md;
    exp_cnt = cnt;
    dump_id++;
    @(posedge clk); #1;
    start = 1;
    n_points = 7'(n);
    tcur = 0;
    out_ready = 1;
    for (int t = 1; t <= 400 && !seen_done; t++) begin
      @(posedge clk); #1;
      tcur = t;
      start = (t == restart_t);
      if (start) n_points = 7'd3;
      out_ready = md == 0 ? 1'b1 : (t % 3 == 2);
      if (t == kill_t) begin
        rst_n = 0;
        #1;
        chk("kill_valid", out_valid, 0);
        chk("kill_busy", busy, 0);
        chk("kill_done", done, 0);
        chk("kill_rec", {out_idx, out_x, out_last}, 0);
        chk("kill_raddr", raddr, 0);
        @(posedge clk); #2;
        rst_n = 1;
        @(negedge clk);
        chk("kill_no_done", done, 0);
        return;
      end
      @(negedge clk);
      if (done) begin
        seen_done = 1;
        chk("done_time", t, n == 0 ? 1 : (md == 0 ? cnt + 2 : last_hs_t + 1));
        chk("records", hs_cnt, cnt);
        chk("busy_at_done", busy, 0);
      end else chk("busy", busy, n > 0);
      if (n == 0) chk("no_valid", out_valid, 0);
      if (n == 5 && md == 0 && t == 6) begin
        chk("lit5_idx", out_idx, 4);
        chk("lit5_yz", {out_y, out_z}, {8'd8, 8'd12});
        chk("lit5_last", {out_valid, out_last}, 2'b11);
      end
      if (n == 5 && md == 0 && t == 5) chk("lit5_notlast", {out_idx, out_last}, {6'd3, 1'b0});
      if (n == 100 && t == 65) begin
        chk("lit100_idx", out_idx, 63);
        chk("lit100_z", out_z, 189);
        chk("lit100_lc", {out_label, out_core, out_last}, {4'd15, 1'b1, 1'b1});
      end
    end
    chk("done_seen", seen_done, 1);
    if (seen_done) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    rst_n = 0; start = 0; n_points = 0; out_ready = 0;
    mode = 0; exp_cnt = 0; dump_id = 0; seen_id = 0; tcur = 0; hs_cnt = 0; last_hs_t = 0;
    stall = 0; prev_rec = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, out_valid, out_last}, 0);
    chk("rst_data", {raddr, out_idx, out_x, out_y, out_z, out_label, out_core}, 0);
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst", {busy, done, out_valid}, 0);
    dump(5, 0, 0, 0);
    dump(5, 1, 0, 0);
    dump(0, 0, 0, 0);
    dump(64, 0, 0, 0);
    dump(100, 0, 0, 0);
    dump(5, 0, 3, 0);
    dump(5, 1, 4, 0);
    dump(5, 0, 0, 5);
    dump(5, 0, 0, 0);
    dump(9, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbscan_result_streamer.md
# dbscan_result_streamer

Read-side companion to the DBSCAN point memory: after clustering finishes, it walks point indices 0..N-1, reads each point's coordinates, cluster label and core flag through the memory's combinational read port, and emits one record per point on a valid/ready output stream. It sits between the point memory and the result sink (UART/DMA packer), and is the only reader of the memory once clustering is idle.

## Interface
- MAX_N, 64: point capacity of the memory; AW = $clog2(MAX_N).

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a dump; sampled only in IDLE
- n_points  in  AW+1  number of points to dump, latched at start
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses
- done  out  1  one-cycle pulse when the final record has been accepted (or on start with n_points==0)
- raddr  out  AW  read address to the point memory
- mem_x, mem_y, mem_z  in  8 each  coordinates at raddr (combinational)
- mem_label  in  4  cluster label at raddr
- mem_core  in  1  core flag at raddr
- out_valid  out  1  output record valid
- out_ready  in  1  sink accepts record
- out_idx  out  AW  point index of the record
- out_x, out_y, out_z  out  8 each  coordinates
- out_label  out  4  cluster label
- out_core  out  1  core flag
- out_last  out  1  record is point n_points-1

## Operation
- States: IDLE, STREAM, FLUSH.
- IDLE: start && n_points==0 -> done pulses next cycle, stay IDLE. start && n_points>0 -> latch count = min(n_points, MAX_N), idx=0, go STREAM.
- STREAM: raddr=idx. Load condition = !out_valid || out_ready. On load: output register captures {idx, mem_*}, out_last = (idx==count-1), out_valid=1, idx+1. If loaded idx==count-1 -> FLUSH.
- FLUSH: hold registered record; on out_valid && out_ready -> out_valid=0, done pulse, go IDLE.
- Output register is the only buffer; record fields never change while out_valid && !out_ready.
- start ignored in STREAM/FLUSH. raddr = 0 in IDLE.
- Memory contents must be stable during a dump (caller's rule); streamer does not write the memory.
- idx is AW bits, compared against count-1; count=MAX_N dumps every entry with no wrap.
- n_points > MAX_N clamps to MAX_N.

## Timing
- Reset (async assert, sync release): state IDLE, idx 0, raddr 0, busy 0, done 0, out_valid 0, out_last 0, all out_* data 0.
- start sampled at edge T -> STREAM/busy from T+1, raddr=0 during T+1, record 0 valid from T+2.
- With out_ready held high: one record per cycle, record k valid in cycle T+2+k, last record in T+1+count; done pulses in T+2+count with busy falling that same cycle.
- Backpressure: out_ready low stalls idx and raddr; no record skipped or duplicated.
- Handshake occurs in the cycle out_valid && out_ready; a new record may be loaded in that same cycle (no bubble).
- n_points==0: done high in T+1 only, busy stays 0, out_valid never rises.
- Reset mid-dump: outputs return to reset values immediately; no done pulse.

## Test plan
- Memory preloaded x=i, y=2i, z=3i, label=i%16, core=i[0]; start, n_points=5, out_ready=1 -> records idx 0..4 back-to-back from T+2, out_last only on idx 4, done in T+7.
- Same dump, out_ready toggling 1,0,0,1,... -> identical record sequence, fields stable during stalls, done one cycle after final handshake.
- n_points=0 -> done pulse at T+1, no out_valid, busy stays 0.
- n_points=MAX_N (64) and n_points=100 -> exactly 64 records, idx 63 carries out_last, no wrap to 0.
- start pulsed again mid-dump -> ignored, sequence unchanged; rst_n low at record 3 -> out_valid/busy/done 0 asynchronously, next start restarts at idx 0.
